// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - TSC opcode/function codes, instruction field positions, encoder FSM state type
//
// Shared with the decoder: opcode and function-code values of the TSC ISA and
// the bit positions of every field inside a 16-bit instruction word.
package instr_encoder_pkg;

    // Opcodes (instruction word bits [15:12])
    localparam logic [3:0] OPCODE_BNE   = 4'd0;
    localparam logic [3:0] OPCODE_BEQ   = 4'd1;
    localparam logic [3:0] OPCODE_BGZ   = 4'd2;
    localparam logic [3:0] OPCODE_BLZ   = 4'd3;
    localparam logic [3:0] OPCODE_ADI   = 4'd4;
    localparam logic [3:0] OPCODE_ORI   = 4'd5;
    localparam logic [3:0] OPCODE_LHI   = 4'd6;
    localparam logic [3:0] OPCODE_LWD   = 4'd7;
    localparam logic [3:0] OPCODE_SWD   = 4'd8;
    localparam logic [3:0] OPCODE_JMP   = 4'd9;
    localparam logic [3:0] OPCODE_JAL   = 4'd10;
    localparam logic [3:0] OPCODE_Rtype = 4'd15;

    // R-type function codes (instruction word bits [5:0])
    localparam logic [5:0] FUNC_ADD = 6'd0;
    localparam logic [5:0] FUNC_SUB = 6'd1;
    localparam logic [5:0] FUNC_AND = 6'd2;
    localparam logic [5:0] FUNC_ORR = 6'd3;
    localparam logic [5:0] FUNC_NOT = 6'd4;
    localparam logic [5:0] FUNC_TCP = 6'd5;
    localparam logic [5:0] FUNC_SHL = 6'd6;
    localparam logic [5:0] FUNC_SHR = 6'd7;
    localparam logic [5:0] FUNC_JPR = 6'd25;
    localparam logic [5:0] FUNC_JRL = 6'd26;
    localparam logic [5:0] FUNC_WWD = 6'd28;
    localparam logic [5:0] FUNC_HLT = 6'd29;

    // Field positions inside the 16-bit word
    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 12;
    localparam int RS_MSB   = 11;
    localparam int RS_LSB   = 10;
    localparam int RT_MSB   = 9;
    localparam int RT_LSB   = 8;
    localparam int RD_MSB   = 7;
    localparam int RD_LSB   = 6;
    localparam int FUNC_MSB = 5;
    localparam int FUNC_LSB = 0;
    localparam int IMM_MSB  = 7;
    localparam int IMM_LSB  = 0;
    localparam int TGT_MSB  = 11;
    localparam int TGT_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_DONE
    } enc_state_t;

    // True when f names an implemented R-type operation.
    function automatic logic func_defined(input logic [5:0] f);
        case (f)
            FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_ORR,
            FUNC_NOT, FUNC_TCP, FUNC_SHL, FUNC_SHR,
            FUNC_JPR, FUNC_JRL, FUNC_WWD, FUNC_HLT: func_defined = 1'b1;
            default:                                func_defined = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - DEPTH x W word FIFO with registered storage and full/empty flags
//
// Ports:
//   clk, reset        clock, synchronous active-high reset (flushes all entries)
//   push, push_data   write request; ignored while full
//   pop               read request; ignored while empty
//   pop_data          head entry (read straight from the storage registers)
//   full, empty       occupancy flags
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    logic do_push;
    logic do_pop;

    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    // A push is refused while full even if a pop frees a slot this same cycle.
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs instruction request fields into TSC words and streams them with addresses
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   start, base_addr        begin a program load at base_addr (only in IDLE/DONE)
//   req_valid, req_ready    request handshake
//   opcode, func_code,
//   rs, rt, rd, imm         instruction fields of the request
//   out_valid, out_ready    output word handshake
//   out_data, out_addr      encoded word and its instruction address
//   err, err_count          dropped-illegal-request pulse and saturating count
//   done                    program fully drained after HLT
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        opcode,
    input  logic [5:0]        func_code,
    input  logic [1:0]        rs,
    input  logic [1:0]        rt,
    input  logic [1:0]        rd,
    input  logic [11:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic [ERR_W-1:0]  err_count,
    output logic              done
);

    enc_state_t state, state_next;

    logic        fifo_full;
    logic        fifo_empty;
    logic        accept;
    logic        push;
    logic        pop;
    logic [15:0] word;
    logic        legal;
    logic        is_hlt;

    // Combinational encoder and legality check
    always_comb begin
        word   = '0;
        legal  = 1'b0;
        is_hlt = 1'b0;
        if (opcode == OPCODE_Rtype) begin
            word[OP_MSB:OP_LSB]     = OPCODE_Rtype;
            word[RS_MSB:RS_LSB]     = rs;
            word[RT_MSB:RT_LSB]     = rt;
            word[RD_MSB:RD_LSB]     = rd;
            word[FUNC_MSB:FUNC_LSB] = func_code;
            legal                   = func_defined(func_code);
            is_hlt                  = (func_code == FUNC_HLT);
        end else if (opcode <= OPCODE_SWD) begin
            word[OP_MSB:OP_LSB]   = opcode;
            word[RS_MSB:RS_LSB]   = rs;
            word[RT_MSB:RT_LSB]   = rt;
            word[IMM_MSB:IMM_LSB] = imm[7:0];
            legal                 = 1'b1;
        end else if (opcode == OPCODE_JMP || opcode == OPCODE_JAL) begin
            word[OP_MSB:OP_LSB]   = opcode;
            word[TGT_MSB:TGT_LSB] = imm;
            legal                 = 1'b1;
        end
    end

    assign req_ready = (state == ST_LOAD) & ~fifo_full;
    // Illegal requests still complete the handshake; they are simply not queued.
    assign accept    = req_valid & req_ready;
    assign push      = accept & legal;
    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;
    assign done      = (state == ST_DONE);

    instr_fifo #(
        .DEPTH (DEPTH),
        .W     (16)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (word),
        .pop       (pop),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_LOAD;
            ST_LOAD:  if (accept && is_hlt) state_next = ST_DRAIN;
            ST_DRAIN: if (fifo_empty) state_next = ST_DONE;
            ST_DONE:  if (start) state_next = ST_LOAD;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            out_addr  <= '0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            state <= state_next;
            err   <= accept & ~legal;
            if (accept && !legal && err_count != '1) begin
                err_count <= err_count + ERR_W'(1);
            end
            // FIFO is always empty in IDLE/DONE, so a load start never races a pop.
            if ((state == ST_IDLE || state == ST_DONE) && start) begin
                out_addr <= base_addr;
            end else if (pop) begin
                out_addr <= out_addr + ADDR_W'(1);
            end
        end
    end

endmodule
